// File: rtl/mlp_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mlp_result_buffer
// Purpose  : Stores a ROWS x COLS result matrix captured from a PE array,
//            CAP_ROWS rows per capture beat. A combinational row-read port
//            feeds the matrix back as the next layer's input. A matrix
//            flagged as the final layer is streamed out OUT_LANES elements
//            per beat with a valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            cap_valid_i, cap_data_i, cap_last_layer_i - capture side
//            rd_row_i, rd_data_o                       - feedback read
//            res_valid_o, res_ready_i, res_data_o,
//            res_last_o                                - result stream
//            busy_o, done_o                            - status
//            cap_drop_o (only with MLP_RESULT_BUFFER_DROP_FLAG_EN defined)
//            - sticky flag set when a capture beat arrives while draining
// Revision : 1.0 - initial release
// ============================================================================
module mlp_result_buffer #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int DW        = 16,
  parameter int CAP_ROWS  = 2,
  parameter int OUT_LANES = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cap_valid_i,
  input  logic [CAP_ROWS*COLS*DW-1:0]             cap_data_i,
  input  logic                                    cap_last_layer_i,
  input  logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] rd_row_i,
  output logic [COLS*DW-1:0]                      rd_data_o,
  output logic                                    res_valid_o,
  input  logic                                    res_ready_i,
  output logic [OUT_LANES*DW-1:0]                 res_data_o,
  output logic                                    res_last_o,
  output logic                                    busy_o,
  output logic                                    done_o
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
  ,
  output logic                                    cap_drop_o
`endif
);

  localparam int SLOTS = ROWS / CAP_ROWS;
  localparam int LPR   = COLS / OUT_LANES;          // output beats per row
  localparam int BEATS = ROWS * COLS / OUT_LANES;
  localparam int RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t                r_state;
  logic [SW-1:0]         r_slot;
  logic [BW-1:0]         r_beat;
  logic                  r_last_layer;
  logic                  r_res_valid;
  logic                  r_done;
  logic [COLS*DW-1:0]    r_buf [ROWS];

  logic                  w_wr_en;
  logic [SW-1:0]         w_wr_slot;
  logic [RW-1:0]         w_row;
  int                    w_col0;
  logic [COLS*DW-1:0]    w_row_data;

  // Capture beats are accepted everywhere except DRAIN. A beat outside
  // CAPTURE always starts a new matrix at slot 0.
  assign w_wr_en   = cap_valid_i && (r_state != S_DRAIN);
  assign w_wr_slot = (r_state == S_CAPTURE) ? r_slot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_beat       <= '0;
      r_last_layer <= 1'b0;
      r_res_valid  <= 1'b0;
      r_done       <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        r_buf[r] <= '0;
      end
    end else begin
      r_done <= 1'b0;

      if (w_wr_en) begin
        for (int r = 0; r < ROWS; r++) begin
          if ((r / CAP_ROWS) == int'(w_wr_slot)) begin
            r_buf[r] <= cap_data_i[(r % CAP_ROWS)*COLS*DW +: COLS*DW];
          end
        end
      end

      case (r_state)
        S_IDLE, S_HOLD: begin
          if (cap_valid_i) begin
            r_last_layer <= cap_last_layer_i;
            if (SLOTS == 1) begin
              // Single-beat matrix: complete using the flag of this beat.
              r_slot      <= '0;
              r_beat      <= '0;
              r_state     <= cap_last_layer_i ? S_DRAIN : S_HOLD;
              r_res_valid <= cap_last_layer_i;
            end else begin
              r_slot  <= SW'(1);
              r_state <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (cap_valid_i) begin
            if (r_slot == SW'(SLOTS - 1)) begin
              r_slot      <= '0;
              r_beat      <= '0;
              r_state     <= r_last_layer ? S_DRAIN : S_HOLD;
              r_res_valid <= r_last_layer;
            end else begin
              r_slot <= r_slot + SW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_res_valid && res_ready_i) begin
            if (r_beat == BW'(BEATS - 1)) begin
              r_beat      <= '0;
              r_state     <= S_IDLE;
              r_res_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
  logic r_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (cap_valid_i && (r_state == S_DRAIN)) begin
      r_drop <= 1'b1;
    end
  end

  assign cap_drop_o = r_drop;
`endif

  // Output beat selection. The buffer cannot change during DRAIN, so the
  // beat data is a pure function of registers and holds across stalls.
  always_comb begin
    w_row      = RW'(int'(r_beat) / LPR);
    w_col0     = (int'(r_beat) % LPR) * OUT_LANES;
    w_row_data = r_buf[w_row];
    res_data_o = '0;
    for (int l = 0; l < OUT_LANES; l++) begin
      // Lowest column of the beat lands in the most significant lane.
      res_data_o[(OUT_LANES-1-l)*DW +: DW] = w_row_data[(w_col0+l)*DW +: DW];
    end
  end

  assign rd_data_o   = r_buf[rd_row_i];
  assign res_valid_o = r_res_valid;
  assign res_last_o  = (r_state == S_DRAIN) && (r_beat == BW'(BEATS - 1));
  assign busy_o      = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
  assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mlp_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_result_buffer
// Purpose  : Self-checking bench for mlp_result_buffer. A default-parameter
//            instance covers hold, drain, stalls, mid-matrix reset and
//            ignored capture beats; a small instance covers single-beat
//            capture. Expected beats are computed from a matrix model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_result_buffer;

  localparam int ROWS = 16, COLS = 16, DW = 16, CAP_ROWS = 2, OUT_LANES = 2;
  localparam int SLOTS = ROWS / CAP_ROWS;
  localparam int BEATS = ROWS * COLS / OUT_LANES;
  localparam int LPR   = COLS / OUT_LANES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst_n;
  logic                          cap_valid;
  logic [CAP_ROWS*COLS*DW-1:0]   cap_data;
  logic                          cap_last;
  logic [3:0]                    rd_row;
  logic [COLS*DW-1:0]            rd_data;
  logic                          res_valid;
  logic                          res_ready;
  logic [OUT_LANES*DW-1:0]       res_data;
  logic                          res_last;
  logic                          busy;
  logic                          done;

  logic                          s_cap_valid;
  logic [4*8*16-1:0]             s_cap_data;
  logic                          s_cap_last;
  logic [1:0]                    s_rd_row;
  logic [8*16-1:0]               s_rd_data;
  logic                          s_res_valid;
  logic                          s_res_ready;
  logic [4*16-1:0]               s_res_data;
  logic                          s_res_last;
  logic                          s_busy;
  logic                          s_done;
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
  logic                          cap_drop;
  logic                          s_cap_drop;
`endif

  mlp_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .cap_valid_i(cap_valid), .cap_data_i(cap_data),
    .cap_last_layer_i(cap_last), .rd_row_i(rd_row), .rd_data_o(rd_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_last_o(res_last), .busy_o(busy), .done_o(done)
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
    , .cap_drop_o(cap_drop)
`endif
  );

  mlp_result_buffer #(.ROWS(4), .COLS(8), .DW(16), .CAP_ROWS(4), .OUT_LANES(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .cap_valid_i(s_cap_valid), .cap_data_i(s_cap_data),
    .cap_last_layer_i(s_cap_last), .rd_row_i(s_rd_row), .rd_data_o(s_rd_data),
    .res_valid_o(s_res_valid), .res_ready_i(s_res_ready), .res_data_o(s_res_data),
    .res_last_o(s_res_last), .busy_o(s_busy), .done_o(s_done)
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
    , .cap_drop_o(s_cap_drop)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Matrix model
  logic [15:0] mat  [ROWS][COLS];
  logic [15:0] smat [4][8];

  // Observations gathered while draining
  logic [31:0] got_data [$];
  bit          got_last [$];
  int          stall_err;
  int          done_cnt;
  int          valid_after_done_err;
  bit          timed_out;

  function automatic logic [31:0] exp_beat(input int b);
    int r, c0;
    r  = b / LPR;
    c0 = (b % LPR) * OUT_LANES;
    return {mat[r][c0], mat[r][c0+1]};
  endfunction

  function automatic logic [COLS*DW-1:0] exp_row(input int r);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = mat[r][c];
    return v;
  endfunction

  task automatic fill_matrix(input bit pattern);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mat[r][c] = pattern ? 16'(r*16 + c) : 16'($urandom);
  endtask

  // Sends nslots capture beats with random gaps; returns on the falling
  // edge right after the final capturing edge.
  task automatic capture_matrix(input bit last, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        cap_valid = 1'b0;
        cap_last  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cap_valid = 1'b1;
      cap_last  = (s == 0) ? last : 1'($urandom_range(0, 1));
      for (int k = 0; k < CAP_ROWS; k++)
        for (int c = 0; c < COLS; c++)
          cap_data[(k*COLS + c)*DW +: DW] = mat[s*CAP_ROWS + k][c];
    end
    @(negedge clk);
    cap_valid = 1'b0;
    cap_last  = 1'b0;
  endtask

  // Drives res_ready (and optionally stray capture beats) and records
  // every handshaken beat plus stall/done behaviour.
  task automatic collect_beats(input bit rnd_ready, input bit inject, input int max_cycles);
    int tail;
    bit stalled, injected;
    logic [31:0] pdata;
    logic plast;
    got_data.delete();
    got_last.delete();
    stall_err = 0; done_cnt = 0; valid_after_done_err = 0; timed_out = 1'b1;
    tail = -1; stalled = 1'b0; injected = 1'b0; pdata = '0; plast = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (stalled && (res_data !== pdata || res_last !== plast || res_valid !== 1'b1))
        stall_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (res_valid !== 1'b0) valid_after_done_err++;
      end
      res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && res_valid === 1'b1) begin
        cap_valid = injected ? 1'($urandom_range(0, 1)) : 1'b1;
        cap_last  = 1'($urandom_range(0, 1));
        for (int w = 0; w < CAP_ROWS*COLS; w++) cap_data[w*DW +: DW] = 16'($urandom);
        if (cap_valid) injected = 1'b1;
      end else begin
        cap_valid = 1'b0;
      end
      stalled = res_valid && !res_ready;
      pdata   = res_data;
      plast   = res_last;
      if (res_valid === 1'b1 && res_ready) begin
        got_data.push_back(res_data);
        got_last.push_back(res_last);
        if (res_last) tail = 3;
      end
      if (tail == 0) begin
        timed_out = 1'b0;
        break;
      end
      if (tail > 0) tail--;
    end
    res_ready = 1'b0;
    cap_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_last !== 1'b0) begin failures++; $display("FAIL reset_res_last got=%b exp=0", res_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      rd_row = 4'(r);
      #1;
      checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_row%0d got=%h exp=0", r, rd_data); end
    end
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
    checks++; if (cap_drop !== 1'b0) begin failures++; $display("FAIL reset_cap_drop got=%b exp=0", cap_drop); end
`endif
  endtask

  task automatic test_hold;
    fill_matrix(1'b1);
    capture_matrix(1'b0, SLOTS);
    rd_row = 4'd15;
    #1;
    checks++; if (rd_data !== exp_row(15)) begin failures++; $display("FAIL hold_row15_next_cycle got=%h exp=%h", rd_data, exp_row(15)); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_idle_outputs cyc=%0d valid=%b busy=%b exp=0,0", i, res_valid, busy); end
      @(negedge clk);
    end
    rd_row = 4'd5;
    #1;
    checks++; if (rd_data !== 256'h005F005E005D005C005B005A0059005800570056005500540053005200510050) begin
      failures++; $display("FAIL hold_row5 got=%h exp=0x50..0x5F", rd_data);
    end
    for (int r = 0; r < ROWS; r++) begin
      rd_row = 4'(r);
      #1;
      checks++; if (rd_data !== exp_row(r)) begin failures++; $display("FAIL hold_row%0d got=%h exp=%h", r, rd_data, exp_row(r)); end
    end
  endtask

  task automatic test_drain_ready;
    int n;
    fill_matrix(1'b1);
    capture_matrix(1'b1, SLOTS);
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL drain_start valid=%b busy=%b exp=1,1", res_valid, busy); end
    collect_beats(1'b0, 1'b0, 400);
    n = got_data.size();
    checks++; if (timed_out) begin failures++; $display("FAIL drain_ready_timeout got=%0d beats exp=%0d", n, BEATS); end
    checks++; if (n != BEATS) begin failures++; $display("FAIL drain_ready_count got=%0d exp=%0d", n, BEATS); end
    if (n >= BEATS) begin
      checks++; if (got_data[0] !== 32'h00000001) begin failures++; $display("FAIL drain_beat0 got=%h exp=00000001", got_data[0]); end
      checks++; if (got_data[BEATS-1] !== 32'h00FE00FF || got_last[BEATS-1] !== 1'b1) begin
        failures++; $display("FAIL drain_beat127 got=%h last=%b exp=00FE00FF last=1", got_data[BEATS-1], got_last[BEATS-1]);
      end
    end
    for (int b = 0; b < n && b < BEATS; b++) begin
      checks++; if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == BEATS-1)) begin
        failures++; $display("FAIL drain_ready_beat%0d got=%h/%b exp=%h/%b", b, got_data[b], got_last[b], exp_beat(b), b == BEATS-1);
      end
    end
    checks++; if (done_cnt != 1 || valid_after_done_err != 0) begin
      failures++; $display("FAIL drain_ready_done pulses=%0d valid_err=%0d exp=1,0", done_cnt, valid_after_done_err);
    end
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL drain_ready_end busy=%b valid=%b exp=0,0", busy, res_valid); end
  endtask

  task automatic test_drain_stall;
    int n, bad;
    fill_matrix(1'b0);
    capture_matrix(1'b1, SLOTS);
    collect_beats(1'b1, 1'b0, 3000);
    n = got_data.size();
    bad = 0;
    checks++; if (timed_out || n != BEATS) begin failures++; $display("FAIL stall_count got=%0d timeout=%b exp=%0d", n, timed_out, BEATS); end
    for (int b = 0; b < n && b < BEATS; b++)
      if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == BEATS-1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_beat_data got=%0d wrong beats exp=0", bad); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", stall_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done got=%0d pulses exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid;
    int n, bad;
    fill_matrix(1'b0);
    capture_matrix(1'b1, 4);
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL midcap_state busy=%b valid=%b exp=1,0", busy, res_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({res_valid, res_last, busy, done} !== 4'b0) begin
      failures++; $display("FAIL async_reset_outputs got=%b exp=0000", {res_valid, res_last, busy, done});
    end
    bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      rd_row = 4'(r);
      #1;
      if (rd_data !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL async_reset_rows got=%0d nonzero rows exp=0", bad); end
    @(negedge clk);
    rst_n = 1'b1;
    fill_matrix(1'b0);
    capture_matrix(1'b1, SLOTS);
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL post_reset_drain_start got=%b exp=1", res_valid); end
    collect_beats(1'b1, 1'b0, 3000);
    n = got_data.size();
    bad = 0;
    for (int b = 0; b < n && b < BEATS; b++)
      if (got_data[b] !== exp_beat(b)) bad++;
    checks++; if (n != BEATS || bad != 0) begin failures++; $display("FAIL post_reset_drain beats=%0d wrong=%0d exp=%0d,0", n, bad, BEATS); end
  endtask

  task automatic test_small;
    logic [63:0] sgot [$];
    bit          slast [$];
    int          sdone, bad;
    logic [63:0] e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) smat[r][c] = 16'($urandom);
    @(negedge clk);
    s_cap_valid = 1'b1;
    s_cap_last  = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 8; c++) s_cap_data[(k*8 + c)*16 +: 16] = smat[k][c];
    @(negedge clk);
    s_cap_valid = 1'b0;
    s_cap_last  = 1'b0;
    checks++; if (s_res_valid !== 1'b1 || s_busy !== 1'b1) begin failures++; $display("FAIL small_drain_next valid=%b busy=%b exp=1,1", s_res_valid, s_busy); end
    s_rd_row = 2'd2;
    #1;
    checks++; if (s_rd_data[3*16 +: 16] !== smat[2][3]) begin failures++; $display("FAIL small_rd got=%h exp=%h", s_rd_data[3*16 +: 16], smat[2][3]); end
    s_res_ready = 1'b1;
    sdone = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (s_res_valid === 1'b1) begin
        sgot.push_back(s_res_data);
        slast.push_back(s_res_last);
      end
      @(negedge clk);
      if (s_done === 1'b1) sdone++;
    end
    s_res_ready = 1'b0;
    checks++; if (sgot.size() != 8) begin failures++; $display("FAIL small_beat_count got=%0d exp=8", sgot.size()); end
    bad = 0;
    for (int b = 0; b < sgot.size() && b < 8; b++) begin
      e = {smat[b/2][(b%2)*4], smat[b/2][(b%2)*4+1], smat[b/2][(b%2)*4+2], smat[b/2][(b%2)*4+3]};
      if (sgot[b] !== e || slast[b] !== (b == 7)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL small_beat_data got=%0d wrong beats exp=0", bad); end
    checks++; if (sdone != 1) begin failures++; $display("FAIL small_done got=%0d pulses exp=1", sdone); end
  endtask

  task automatic test_drop_ignore;
    int n, bad;
    fill_matrix(1'b0);
    capture_matrix(1'b1, SLOTS);
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
    checks++; if (cap_drop !== 1'b0) begin failures++; $display("FAIL drop_before got=%b exp=0", cap_drop); end
`endif
    collect_beats(1'b1, 1'b1, 3000);
    n = got_data.size();
    bad = 0;
    for (int b = 0; b < n && b < BEATS; b++)
      if (got_data[b] !== exp_beat(b) || got_last[b] !== (b == BEATS-1)) bad++;
    checks++; if (timed_out || n != BEATS || bad != 0) begin
      failures++; $display("FAIL drop_drain beats=%0d wrong=%0d timeout=%b exp=%0d,0,0", n, bad, timed_out, BEATS);
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL drop_done got=%0d pulses exp=1", done_cnt); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL drop_end_state busy=%b valid=%b exp=0,0", busy, res_valid); end
    bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      rd_row = 4'(r);
      #1;
      if (rd_data !== exp_row(r)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL drop_buffer_changed got=%0d rows differ exp=0", bad); end
`ifdef MLP_RESULT_BUFFER_DROP_FLAG_EN
    checks++; if (cap_drop !== 1'b1) begin failures++; $display("FAIL drop_flag_set got=%b exp=1", cap_drop); end
    repeat (4) @(negedge clk);
    checks++; if (cap_drop !== 1'b1) begin failures++; $display("FAIL drop_flag_sticky got=%b exp=1", cap_drop); end
    checks++; if (s_cap_drop !== 1'b0) begin failures++; $display("FAIL drop_small_flag got=%b exp=0", s_cap_drop); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cap_valid = 1'b0; cap_data = '0; cap_last = 1'b0; rd_row = '0; res_ready = 1'b0;
    s_cap_valid = 1'b0; s_cap_data = '0; s_cap_last = 1'b0; s_rd_row = '0; s_res_ready = 1'b0;
    test_reset;
    test_hold;
    test_drain_ready;
    test_drain_stall;
    test_reset_mid;
    test_small;
    test_drop_ignore;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
